pico_sequencer: RTL and testbench
=================================

Name: pico_sequencer

Overview:
- Instruction sequencer for the picoMIPS core. It owns the program counter and sits between the instruction decoder and the PC, register file and multiplier.
- Synchronises and debounces the hold switch, and generates the holdflag handshake that the decoder's HOLD instruction compares against.
- Stalls the PC and gates the register write for multi-cycle MUL.

Parameters:
- PSIZE, 5, program counter width in bits; PC wraps modulo 2^PSIZE.
- MUL_LAT, 2, extra cycles the multiplier needs; 0 means MUL completes in one cycle like ADD.
- DB_CYC, 4, consecutive stable cycles required before the debounced switch changes; must be at least 1.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- opcode  input  4  current instruction opcode; values per the shared opcode definitions (`ADD, `ADDI, `MUL, `SUB, `HOLD)
- pcincr_dec  input  1  decoder PC-increment request
- w_dec  input  1  decoder register-write request
- swhold_raw  input  1  raw, asynchronous hold switch
- swhold  output  1  synchronised, debounced switch, fed to decoder
- holdflag  output  1  hold handshake flag, fed to decoder
- pc  output  PSIZE  program memory address
- w  output  1  gated register-file write enable
- mul_busy  output  1  high while the sequencer is stalling for MUL
- step_raw  input  1  raw single-step button; present only with PICO_SINGLE_STEP_EN

Behaviour:
- One clock, clk. Reset is synchronous, active-high, and overrides everything.
- Reset values:
  - pc=0, holdflag=0, swhold=0
  - synchroniser flops=0, debounce counter=0
  - state=RUN, mul_busy=0
  - w=0 during the reset cycle
- Switch path: swhold_raw passes through a 2-flop synchroniser, then the debouncer.
  - The debounced output changes only after the synchronised value has differed from it for DB_CYC consecutive cycles.
  - Any glitch back to the current value clears the counter.
  - Latency from a clean raw change to swhold: 2+DB_CYC cycles.
- States: RUN, MULW, HOLDW.
- RUN:
  - w=w_dec.
  - pc<=pc+1 when pcincr_dec=1.
  - If opcode=`MUL and MUL_LAT>0: w=0, pc held, count<=MUL_LAT, go to MULW.
  - If opcode=`HOLD and pcincr_dec=0: go to HOLDW, pc held.
  - If opcode=`HOLD and pcincr_dec=1 (switch already equals holdflag): pc<=pc+1, holdflag toggles, stay in RUN.
- MULW:
  - mul_busy=1, pc held, opcode ignored.
  - count decrements each cycle.
  - In the cycle with count=1: w=w_dec. At that edge, pc<=pc+1 and the state returns to RUN.
  - Total MUL occupancy is MUL_LAT+1 cycles, with exactly one write pulse.
- HOLDW:
  - w=0, pc held.
  - When pcincr_dec=1: pc<=pc+1, holdflag toggles, return to RUN.
  - Each switch flip therefore releases exactly one HOLD.
- pc wraps from 2^PSIZE-1 to 0 with no flag.
- Reset during MULW or HOLDW: the state returns to RUN on the next edge, with no write pulse and no holdflag toggle.
- An opcode not listed above behaves as a RUN-state pass-through of the decoder outputs.

Optional Feature:
- Macro: PICO_SINGLE_STEP_EN.
- Defined:
  - step_raw port exists and gets its own synchroniser and debouncer.
  - In RUN, pc advances and w is permitted only in the cycle after a debounced rising edge of step_raw; otherwise pc is held and w=0.
  - MULW and HOLDW complete normally once entered.
- Undefined: no step_raw port; the sequencer free-runs as described above.

Decomposition:
- Package pico_seq_pkg holds:
  - seq_state_t enum {RUN, MULW, HOLDW}
  - a localparam function for counter width, $clog2(N+1)
- Opcode values stay in the existing shared opcode definitions.
- Natural sub-module: sw_debounce (2-flop sync, DB_CYC counter, stable output; parameter DB_CYC). Instantiated once for swhold_raw, and a second time for step_raw under the macro.

Test Plan:
- Reset with pcincr_dec=1 held for 3 cycles, then release reset with opcode=`ADD, w_dec=1 -> pc=0, w=0 during reset; then pc 1,2,3 on successive edges, w=1.
- opcode=`MUL, MUL_LAT=2, w_dec=1 at pc=4 -> mul_busy=1 for 2 cycles, w=0,0,1 over 3 cycles, pc=5 after the third edge.
- opcode=`HOLD, holdflag=0, swhold=1, decoder pcincr_dec=0 -> HOLDW, pc frozen. Drive swhold_raw=0 cleanly -> after 2+4 cycles swhold=0, pcincr_dec=1, pc advances, holdflag=1.
- swhold_raw toggles every 2 cycles for 20 cycles with DB_CYC=4 -> swhold never changes.
- Assert reset during the second MULW cycle -> next edge: state RUN, pc=0, no w pulse, mul_busy=0.
- PSIZE=5, pc=31, pcincr_dec=1 -> pc=0. With PICO_SINGLE_STEP_EN: no step press -> pc constant for 10 cycles; one clean press -> pc+1 exactly once.

Source files
------------

// File: rtl/pico_seq_pkg.sv
// Shared types and helpers for the picoMIPS instruction sequencer.
// Supplies fallback opcode macros when the shared opcode definitions are absent.
`ifndef ADD
`define ADD  4'd0
`define ADDI 4'd1
`define MUL  4'd2
`define SUB  4'd3
`define HOLD 4'd4
`endif

package pico_seq_pkg;

    typedef enum logic [1:0] {RUN, MULW, HOLDW} seq_state_t;

    // Width of a counter that must hold values 0..n; never narrower than 1 bit.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/pico_sequencer_sw_debounce.sv
// Two-flop synchroniser plus debouncer for a raw switch or button.
// The output follows the synchronised input after DB_CYC consecutive differing cycles.
module sw_debounce
    import pico_seq_pkg::*;
#(
    parameter int DB_CYC = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic stable
);

    localparam int CW = cnt_width(DB_CYC);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            cnt    <= '0;
            stable <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            // Any return to the current output restarts the stability window.
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CW'(DB_CYC - 1)) begin
                stable <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/pico_sequencer.sv
// picoMIPS instruction sequencer: owns the PC, stalls for MUL, handles HOLD handshake.
// Optional single-step button enabled by defining PICO_SINGLE_STEP_EN.
module pico_sequencer
    import pico_seq_pkg::*;
#(
    parameter int PSIZE   = 5,
    parameter int MUL_LAT = 2,
    parameter int DB_CYC  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       opcode,
    input  logic             pcincr_dec,
    input  logic             w_dec,
    input  logic             swhold_raw,
`ifdef PICO_SINGLE_STEP_EN
    input  logic             step_raw,
`endif
    output logic             swhold,
    output logic             holdflag,
    output logic [PSIZE-1:0] pc,
    output logic             w,
    output logic             mul_busy
);

    // state | meaning
    // RUN   | normal issue: PC and write follow the decoder
    // MULW  | multiplier busy: PC frozen, write only on the final cycle
    // HOLDW | waiting for the switch to flip: PC frozen, no writes

    localparam int CW = cnt_width(MUL_LAT);

    seq_state_t       state, state_n;
    logic [CW-1:0]    count, count_n;
    logic [PSIZE-1:0] pc_n;
    logic             holdflag_n;
    logic             run_ok;

    sw_debounce #(.DB_CYC(DB_CYC)) u_swhold (
        .clk    (clk),
        .reset  (reset),
        .raw    (swhold_raw),
        .stable (swhold)
    );

`ifdef PICO_SINGLE_STEP_EN
    logic step_db;
    logic step_prev;

    sw_debounce #(.DB_CYC(DB_CYC)) u_step (
        .clk    (clk),
        .reset  (reset),
        .raw    (step_raw),
        .stable (step_db)
    );

    always_ff @(posedge clk) begin
        if (reset) step_prev <= 1'b0;
        else       step_prev <= step_db;
    end

    // RUN may issue only in the single cycle following a debounced press.
    assign run_ok = step_db & ~step_prev;
`else
    assign run_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= RUN;
            count    <= '0;
            pc       <= '0;
            holdflag <= 1'b0;
        end else begin
            state    <= state_n;
            count    <= count_n;
            pc       <= pc_n;
            holdflag <= holdflag_n;
        end
    end

    always_comb begin
        state_n    = state;
        count_n    = count;
        pc_n       = pc;
        holdflag_n = holdflag;
        w          = 1'b0;
        mul_busy   = 1'b0;
        if (!reset) begin
            unique case (state)
                RUN: begin
                    if (run_ok) begin
                        if (opcode == `MUL && MUL_LAT > 0) begin
                            count_n = CW'(MUL_LAT);
                            state_n = MULW;
                        end else begin
                            w = w_dec;
                            if (opcode == `HOLD && !pcincr_dec) begin
                                state_n = HOLDW;
                            end else if (pcincr_dec) begin
                                pc_n = pc + PSIZE'(1);
                                if (opcode == `HOLD) holdflag_n = ~holdflag;
                            end
                        end
                    end
                end
                MULW: begin
                    mul_busy = 1'b1;
                    count_n  = count - CW'(1);
                    if (count == CW'(1)) begin
                        w       = w_dec;
                        pc_n    = pc + PSIZE'(1);
                        state_n = RUN;
                    end
                end
                HOLDW: begin
                    if (pcincr_dec) begin
                        pc_n       = pc + PSIZE'(1);
                        holdflag_n = ~holdflag;
                        state_n    = RUN;
                    end
                end
                default: state_n = RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_pico_sequencer.sv
// Randomised scoreboard bench for pico_sequencer against a behavioural model.
module tb_pico_sequencer;

    localparam int PSIZE   = 5;
    localparam int MUL_LAT = 2;
    localparam int DB_CYC  = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [3:0]       opcode;
    logic             pcincr_dec;
    logic             w_dec;
    logic             swhold_raw;
`ifdef PICO_SINGLE_STEP_EN
    logic             step_raw;
`endif
    logic             swhold;
    logic             holdflag;
    logic [PSIZE-1:0] pc;
    logic             w;
    logic             mul_busy;

    always #5 clk = ~clk;

    pico_sequencer #(.PSIZE(PSIZE), .MUL_LAT(MUL_LAT), .DB_CYC(DB_CYC)) dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .pcincr_dec (pcincr_dec),
        .w_dec      (w_dec),
        .swhold_raw (swhold_raw),
`ifdef PICO_SINGLE_STEP_EN
        .step_raw   (step_raw),
`endif
        .swhold     (swhold),
        .holdflag   (holdflag),
        .pc         (pc),
        .w          (w),
        .mul_busy   (mul_busy)
    );

    typedef struct {
        logic [31:0] pc;
        bit          w;
        bit          busy;
        bit          hf;
        bit          sw;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: plain counters describing program flow, not FSM encodings.
    int m_pc;
    int mul_left;
    bit in_hold;
    bit m_hf;
    bit m_step_prev;
    bit db_s1[2];
    bit db_s2[2];
    bit db_out[2];
    int db_streak[2];

    function automatic bit step_ok();
`ifdef PICO_SINGLE_STEP_EN
        return db_out[1] && !m_step_prev;
`else
        return 1'b1;
`endif
    endfunction

    task automatic db_edge(input int i, input bit rst, input bit raw);
        if (rst) begin
            db_s1[i] = 0; db_s2[i] = 0; db_out[i] = 0; db_streak[i] = 0;
        end else begin
            if (db_s2[i] != db_out[i]) begin
                db_streak[i]++;
                if (db_streak[i] == DB_CYC) begin
                    db_out[i]    = db_s2[i];
                    db_streak[i] = 0;
                end
            end else begin
                db_streak[i] = 0;
            end
            db_s2[i] = db_s1[i];
            db_s1[i] = raw;
        end
    endtask

    task automatic advance();
        m_pc = (m_pc + 1) % (1 << PSIZE);
    endtask

    task automatic model_edge(input bit rst, input logic [3:0] op, input bit pinc,
                              input bit raw, input bit sraw);
        bit ok;
        ok = step_ok();
        if (rst) begin
            m_pc = 0; mul_left = 0; in_hold = 0; m_hf = 0;
        end else if (mul_left > 0) begin
            mul_left--;
            if (mul_left == 0) advance();
        end else if (in_hold) begin
            if (pinc) begin advance(); m_hf = !m_hf; in_hold = 0; end
        end else if (ok) begin
            if (op == `MUL && MUL_LAT > 0) mul_left = MUL_LAT;
            else if (op == `HOLD) begin
                if (pinc) begin advance(); m_hf = !m_hf; end
                else in_hold = 1;
            end else if (pinc) advance();
        end
        m_step_prev = rst ? 1'b0 : db_out[1];
        db_edge(0, rst, raw);
        db_edge(1, rst, sraw);
    endtask

    task automatic push_expected(input bit rst, input logic [3:0] op, input bit wd);
        exp_t e;
        e.pc = 32'(m_pc); e.hf = m_hf; e.sw = db_out[0]; e.w = 0; e.busy = 0;
        if (!rst) begin
            if (mul_left > 0) begin
                e.busy = 1;
                if (mul_left == 1) e.w = wd;
            end else if (!in_hold && step_ok() && !(op == `MUL && MUL_LAT > 0)) begin
                e.w = wd;
            end
        end
        sb.push_back(e);
    endtask

    task automatic cyc(input bit rst, input logic [3:0] op, input bit pinc, input bit wd,
                       input bit raw, input bit sraw);
        reset = rst; opcode = op; pcincr_dec = pinc; w_dec = wd; swhold_raw = raw;
`ifdef PICO_SINGLE_STEP_EN
        step_raw = sraw;
`endif
        push_expected(rst, op, wd);
        @(posedge clk);
        model_edge(rst, op, pinc, raw, sraw);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("pc",       32'(pc),       e.pc);
            chk("w",        32'(w),        32'(e.w));
            chk("mul_busy", 32'(mul_busy), 32'(e.busy));
            chk("holdflag", 32'(holdflag), 32'(e.hf));
            chk("swhold",   32'(swhold),   32'(e.sw));
        end
    end

    logic [3:0] ops[6];
    bit         base;
    bit         raw_r;
    bit         step_r;

    initial begin
        ops = '{`ADD, `ADDI, `MUL, `SUB, `HOLD, 4'hF};
        reset = 1; opcode = `ADD; pcincr_dec = 1; w_dec = 1; swhold_raw = 0;
`ifdef PICO_SINGLE_STEP_EN
        step_raw = 0;
`endif
        @(posedge clk);
        model_edge(1, `ADD, 1, 0, 0);
        #1;

        // Reset with increment requested, then free run.
        repeat (3) cyc(1, `ADD, 1, 1, 1, 0);
        repeat (4) cyc(0, `ADD, 1, 1, 1, 0);
        // MUL stall: MULW cycles present ADD to show the opcode is ignored.
        cyc(0, `MUL, 1, 1, 1, 0);
        repeat (2) cyc(0, `ADD, 1, 1, 1, 0);
        repeat (6) cyc(0, `ADD, 0, 0, 1, 0);
        // HOLD handshake: decoder increments only when switch equals holdflag.
        repeat (4) cyc(0, `HOLD, db_out[0] == m_hf, 0, 1, 0);
        repeat (12) cyc(0, `HOLD, db_out[0] == m_hf, 1, 0, 0);
        repeat (12) cyc(0, `HOLD, db_out[0] == m_hf, 1, 1, 0);
        // Glitching switch never settles long enough to change swhold.
        base = db_out[0];
        for (int i = 0; i < 20; i++) cyc(0, `ADD, 1, 1, base ^ (((i >> 1) & 1) == 0), 0);
        repeat (4) cyc(0, `ADD, 1, 1, base, 0);
        // Reset landing in the second MULW cycle.
        cyc(0, `MUL, 1, 1, base, 0);
        cyc(0, `ADD, 1, 1, base, 0);
        cyc(1, `ADD, 1, 1, base, 0);
        cyc(0, `ADD, 1, 1, base, 0);
        // PC wrap.
        repeat (40) cyc(0, `ADD, 1, 1, base, 0);

        raw_r = base; step_r = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 11) == 0) raw_r = !raw_r;
            if ($urandom_range(0, 9) == 0)  step_r = !step_r;
            cyc($urandom_range(0, 99) == 0, ops[$urandom_range(0, 5)],
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), raw_r, step_r);
        end

        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
